// File: rtl/pipeline_fetch.sv
// ----------------------------------------------------------------------------
// pipeline_fetch
//
// Instruction fetch stage. Holds the PC, issues in-order word reads to
// instruction memory under a credit limit, buffers returned words in a small
// queue and presents them to decode one per cycle. Empty slots are presented
// as all-zero (NOP) bubbles. A redirect loads a new PC, flushes the queue and
// arranges for every read still in flight to be discarded on return.
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-high reset
//   imem_req_valid   read request valid (combinational)
//   imem_req_ready   memory accepts the request this cycle
//   imem_req_addr    word address of the request (current PC)
//   imem_resp_valid  read data valid (in order, no backpressure)
//   imem_resp_data   returned instruction word
//   redirect_valid   load redirect_pc and squash the old stream
//   redirect_pc      redirect target; bits [1:0] ignored
//   stall            decode not accepting; outputs hold
//   inst_out         instruction to decode, 0 when no instruction is valid
//   inst_pc          PC of inst_out, 0 when no instruction is valid
//   inst_valid       inst_out carries a real fetched instruction
// ----------------------------------------------------------------------------
module pipeline_fetch #(
    parameter logic [31:0] RESET_PC    = 32'hBFC00000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_valid
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;

    // Architectural state
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;

    // In-flight PC FIFO: PC of each accepted, not yet returned read
    logic [31:0]   if_pc_q [QUEUE_DEPTH];
    logic [PW-1:0] if_wr_q, if_wr_d;
    logic [PW-1:0] if_rd_q, if_rd_d;

    // Instruction queue
    logic [31:0]   q_data_q [QUEUE_DEPTH];
    logic [31:0]   q_pc_q   [QUEUE_DEPTH];
    logic [PW-1:0] q_head_q, q_head_d;
    logic [PW-1:0] q_tail_q, q_tail_d;
    logic [CW-1:0] q_cnt_q, q_cnt_d;

    // Output register
    logic [31:0]   out_inst_q, out_inst_d;
    logic [31:0]   out_pc_q, out_pc_d;
    logic          out_vld_q, out_vld_d;

    // Handshake / datapath control
    logic [CW-1:0] occ;
    logic          req_fire;
    logic          resp_fire;
    logic          discard;
    logic          resp_keep;
    logic          bypass;
    logic          q_push;
    logic          q_pop;
    logic [31:0]   resp_pc;

    // Low address bits of the redirect target are forced to zero
    logic          unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // ------------------------------------------------------------------------
    // Request side: credit covers both reads in flight and words queued, so
    // a returning word always has a free queue slot.
    // ------------------------------------------------------------------------
    assign occ            = outst_q + q_cnt_q;
    assign imem_req_valid = !rst && !redirect_valid && (occ < CW'(QUEUE_DEPTH));
    assign imem_req_addr  = pc_q;

    always_comb begin
        req_fire  = imem_req_valid && imem_req_ready;
        resp_fire = imem_resp_valid;
        resp_pc   = if_pc_q[if_rd_q];

        // Stale responses (older than a redirect) and any response that
        // coincides with a redirect never enter the queue.
        discard   = (drop_q != '0) || redirect_valid;
        resp_keep = resp_fire && !discard;

        // A kept word goes straight to the output register when the queue is
        // empty and decode is accepting; otherwise it is queued.
        bypass    = resp_keep && (q_cnt_q == '0) && !stall;
        q_push    = resp_keep && !bypass;
        q_pop     = !stall && !redirect_valid && (q_cnt_q != '0);
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(resp_fire);
        drop_d     = drop_q;
        if_wr_d    = if_wr_q;
        if_rd_d    = if_rd_q;
        q_head_d   = q_head_q;
        q_tail_d   = q_tail_q;
        q_cnt_d    = q_cnt_q + CW'(q_push) - CW'(q_pop);
        out_inst_d = out_inst_q;
        out_pc_d   = out_pc_q;
        out_vld_d  = out_vld_q;

        if (req_fire) begin
            pc_d    = pc_q + 32'd4;
            if_wr_d = if_wr_q + PW'(1);
        end

        if (resp_fire) begin
            if_rd_d = if_rd_q + PW'(1);
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
        end

        if (q_push) begin
            q_tail_d = q_tail_q + PW'(1);
        end
        if (q_pop) begin
            q_head_d = q_head_q + PW'(1);
        end

        // Redirect: everything still in flight becomes stale. The in-flight
        // PC FIFO is not reset because stale responses still pop it.
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            drop_d   = outst_q - CW'(resp_fire);
            q_head_d = q_tail_q;
            q_cnt_d  = '0;
        end

        // Output register; a redirect does not squash a held instruction
        if (!stall) begin
            if (redirect_valid) begin
                out_inst_d = '0;
                out_pc_d   = '0;
                out_vld_d  = 1'b0;
            end else if (q_pop) begin
                out_inst_d = q_data_q[q_head_q];
                out_pc_d   = q_pc_q[q_head_q];
                out_vld_d  = 1'b1;
            end else if (bypass) begin
                out_inst_d = imem_resp_data;
                out_pc_d   = resp_pc;
                out_vld_d  = 1'b1;
            end else begin
                out_inst_d = '0;
                out_pc_d   = '0;
                out_vld_d  = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            if_wr_q    <= '0;
            if_rd_q    <= '0;
            q_head_q   <= '0;
            q_tail_q   <= '0;
            q_cnt_q    <= '0;
            out_inst_q <= '0;
            out_pc_q   <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            if_wr_q    <= if_wr_d;
            if_rd_q    <= if_rd_d;
            q_head_q   <= q_head_d;
            q_tail_q   <= q_tail_d;
            q_cnt_q    <= q_cnt_d;
            out_inst_q <= out_inst_d;
            out_pc_q   <= out_pc_d;
            out_vld_q  <= out_vld_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage arrays: contents are only meaningful behind the pointers, so
    // they carry no reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (req_fire) begin
            if_pc_q[if_wr_q] <= pc_q;
        end
        if (q_push) begin
            q_data_q[q_tail_q] <= imem_resp_data;
            q_pc_q[q_tail_q]   <= resp_pc;
        end
    end

    assign inst_out   = out_inst_q;
    assign inst_pc    = out_pc_q;
    assign inst_valid = out_vld_q;

endmodule
